// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product vending controller.
// Credit is kept in nickel units. Each product has its own price. The machine
// supports cancel/refund. Change is paid out serially, one coin per cycle, chosen
// greedily (quarter, then dime, then nickel). Every output is registered.
//
// Optional feature: define VM_STOCK_EN to add a per-product stock counter that
// starts at STOCK_INIT. When it is defined, a vend of an empty product returns a
// sold_out_o pulse. When it is undefined, stock is unlimited and sold_out_o stays 0.

module vending_machine_multi #(
    parameter int unsigned                 NUM_PROD    = 4,
    parameter int unsigned                 CRED_W      = 6,
    parameter logic [NUM_PROD*CRED_W-1:0]  PRICE_TABLE = {6'd6, 6'd5, 6'd4, 6'd3},
    parameter int unsigned                 STOCK_INIT  = 8,
    localparam int unsigned                SEL_W       = $clog2(NUM_PROD)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              nickle_i,
    input  logic              dime_i,
    input  logic              quarter_i,
    input  logic              vend_req_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              cancel_i,
    output logic              soda_o,
    output logic [SEL_W-1:0]  vend_sel_o,
    output logic [2:0]        change_o,
    output logic [CRED_W-1:0] credit_o,
    output logic              busy_o,
    output logic              coin_reject_o,
    output logic              insufficient_o,
    output logic              sold_out_o
);

    localparam logic [SEL_W:0] NUM_PROD_W = (SEL_W + 1)'(NUM_PROD);

    // Change coin encodings {quarter, dime, nickel}
    localparam logic [2:0] COIN_Q = 3'b100;
    localparam logic [2:0] COIN_D = 3'b010;
    localparam logic [2:0] COIN_N = 3'b001;

    if (NUM_PROD < 2 || STOCK_INIT == 0) begin : g_param_check
        $error("vending_machine_multi: NUM_PROD must be >= 2 and STOCK_INIT >= 1");
    end

    typedef enum logic [0:0] {
        StAccept,
        StChange
    } state_e;

    state_e              r_state, w_state_next;
    logic [CRED_W-1:0]   r_credit, w_credit_next;
    logic [CRED_W-1:0]   r_rem, w_rem_next;
    logic                r_soda, w_soda_next;
    logic [SEL_W-1:0]    r_vend_sel, w_vend_sel_next;
    logic [2:0]          r_change, w_change_next;
    logic                r_busy, w_busy_next;
    logic                r_coin_reject, w_coin_reject_next;
    logic                r_insufficient, w_insufficient_next;
    logic                r_sold_out, w_sold_out_next;

    logic [1:0]          w_coin_cnt;
    logic                w_any_coin;
    logic                w_one_coin;
    logic [2:0]          w_coin_val;
    logic [CRED_W:0]     w_coin_sum;
    logic                w_coin_ovf;
    logic [CRED_W-1:0]   w_price;
    logic                w_sel_valid;
    logic                w_credit_ok;
    logic [CRED_W-1:0]   w_vend_rem;
    logic                w_sold_out_sel;
    logic                w_taken;
    logic [CRED_W-1:0]   w_rem_after;

    // Coin strobe decode: a value is credited only when exactly one strobe is high
    always_comb begin
        w_coin_cnt = {1'b0, nickle_i} + {1'b0, dime_i} + {1'b0, quarter_i};
        w_any_coin = nickle_i | dime_i | quarter_i;
        w_one_coin = (w_coin_cnt == 2'd1);
        w_coin_val = 3'd0;
        if (quarter_i) begin
            w_coin_val = 3'd5;
        end else if (dime_i) begin
            w_coin_val = 3'd2;
        end else if (nickle_i) begin
            w_coin_val = 3'd1;
        end
        // The extra top bit flags a sum that would exceed the credit range
        w_coin_sum = {1'b0, r_credit} + (CRED_W + 1)'(w_coin_val);
        w_coin_ovf = w_coin_sum[CRED_W];
    end

    // Price lookup for the selected product; out-of-range selects read zero and
    // are refused separately through w_sel_valid
    always_comb begin
        w_price = '0;
        for (int k = 0; k < NUM_PROD; k++) begin
            if (sel_i == SEL_W'(k)) begin
                w_price = PRICE_TABLE[k*CRED_W +: CRED_W];
            end
        end
        w_sel_valid = ({1'b0, sel_i} < NUM_PROD_W);
        w_credit_ok = (r_credit >= w_price);
        w_vend_rem  = r_credit - w_price;
    end

`ifdef VM_STOCK_EN
    localparam int unsigned STK_W = $clog2(STOCK_INIT + 1);

    logic [STK_W-1:0] r_stock [NUM_PROD];
    logic             w_stock_dec;

    // Sold-out lookup for the selected product
    always_comb begin
        w_sold_out_sel = 1'b0;
        for (int k = 0; k < NUM_PROD; k++) begin
            if (sel_i == SEL_W'(k)) begin
                w_sold_out_sel = (r_stock[k] == '0);
            end
        end
    end

    // Per-product stock counters: decrement on a successful vend and saturate at zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_PROD; k++) begin
                r_stock[k] <= STK_W'(STOCK_INIT);
            end
        end else if (w_stock_dec) begin
            for (int k = 0; k < NUM_PROD; k++) begin
                if (sel_i == SEL_W'(k) && r_stock[k] != '0) begin
                    r_stock[k] <= r_stock[k] - STK_W'(1);
                end
            end
        end
    end
`else
    assign w_sold_out_sel = 1'b0;
`endif

    // Next-state and registered-output logic for the ACCEPT/CHANGE controller
    always_comb begin
        w_state_next        = r_state;
        w_credit_next       = r_credit;
        w_rem_next          = r_rem;
        w_soda_next         = 1'b0;
        w_vend_sel_next     = '0;
        w_change_next       = 3'b000;
        w_busy_next         = 1'b0;
        w_coin_reject_next  = 1'b0;
        w_insufficient_next = 1'b0;
        w_sold_out_next     = 1'b0;
        w_taken             = 1'b0;
        w_rem_after         = r_rem;
`ifdef VM_STOCK_EN
        w_stock_dec         = 1'b0;
`endif

        unique case (r_state)
            StAccept: begin
                if (cancel_i && r_credit != '0) begin
                    w_rem_next    = r_credit;
                    w_credit_next = '0;
                    w_state_next  = StChange;
                    w_busy_next   = 1'b1;
                    w_taken       = 1'b1;
                end else if (vend_req_i) begin
                    if (!w_sel_valid) begin
                        w_insufficient_next = 1'b1;
                    end else if (w_sold_out_sel) begin
                        w_sold_out_next = 1'b1;
                    end else if (!w_credit_ok) begin
                        w_insufficient_next = 1'b1;
                    end else begin
                        w_soda_next     = 1'b1;
                        w_vend_sel_next = sel_i;
                        w_credit_next   = '0;
                        w_rem_next      = w_vend_rem;
                        w_taken         = 1'b1;
`ifdef VM_STOCK_EN
                        w_stock_dec     = 1'b1;
`endif
                        if (w_vend_rem != '0) begin
                            w_state_next = StChange;
                            w_busy_next  = 1'b1;
                        end
                    end
                end

                // A coin that arrives with an accepted cancel or vend is always
                // returned, so that credit is never silently lost
                if (w_any_coin) begin
                    if (w_taken || !w_one_coin || w_coin_ovf) begin
                        w_coin_reject_next = 1'b1;
                    end else begin
                        w_credit_next = w_coin_sum[CRED_W-1:0];
                    end
                end
            end

            StChange: begin
                w_coin_reject_next = w_any_coin;
                if (r_rem >= CRED_W'(5)) begin
                    w_change_next = COIN_Q;
                    w_rem_after   = r_rem - CRED_W'(5);
                end else if (r_rem >= CRED_W'(2)) begin
                    w_change_next = COIN_D;
                    w_rem_after   = r_rem - CRED_W'(2);
                end else if (r_rem != '0) begin
                    w_change_next = COIN_N;
                    w_rem_after   = r_rem - CRED_W'(1);
                end else begin
                    w_rem_after   = '0;
                end
                w_rem_next = w_rem_after;
                // busy_o tracks the cycles in which the FSM sits in CHANGE
                if (w_rem_after == '0) begin
                    w_state_next = StAccept;
                end else begin
                    w_busy_next  = 1'b1;
                end
            end

            default: begin
                w_state_next = StAccept;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= StAccept;
            r_credit       <= '0;
            r_rem          <= '0;
            r_soda         <= 1'b0;
            r_vend_sel     <= '0;
            r_change       <= 3'b000;
            r_busy         <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_insufficient <= 1'b0;
            r_sold_out     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_credit       <= w_credit_next;
            r_rem          <= w_rem_next;
            r_soda         <= w_soda_next;
            r_vend_sel     <= w_vend_sel_next;
            r_change       <= w_change_next;
            r_busy         <= w_busy_next;
            r_coin_reject  <= w_coin_reject_next;
            r_insufficient <= w_insufficient_next;
            r_sold_out     <= w_sold_out_next;
        end
    end

    assign soda_o         = r_soda;
    assign vend_sel_o     = r_vend_sel;
    assign change_o       = r_change;
    assign credit_o       = r_credit;
    assign busy_o         = r_busy;
    assign coin_reject_o  = r_coin_reject;
    assign insufficient_o = r_insufficient;
    assign sold_out_o     = r_sold_out;

endmodule
